// File: rtl/clk_period_mon_pkg.sv
// clk_period_mon shared types and helpers.
// FSM state encoding and the tolerance check used by every channel.
package clk_period_mon_pkg;

  // Widest supported counter; tolerance math is done one bit wider.
  localparam int MAX_W = 32;

  typedef enum logic {
    ST_ARM  = 1'b0,
    ST_MEAS = 1'b1
  } ch_state_e;

  // |p - e| <= t, computed without wrap on a widened difference.
  function automatic logic in_tol(
    input logic [MAX_W-1:0] p,
    input logic [MAX_W-1:0] e,
    input logic [MAX_W-1:0] t
  );
    logic [MAX_W:0] w_diff;
    if (p >= e) begin
      w_diff = {1'b0, p} - {1'b0, e};
    end else begin
      w_diff = {1'b0, e} - {1'b0, p};
    end
    return w_diff <= {1'b0, t};
  endfunction

endpackage

// File: rtl/clk_period_mon_ch.sv
// One clk_period_mon channel: edge detect, period counter, FSM, check.
// Optional min/max tracking is built with CLK_PERIOD_MON_MINMAX_EN.
module clk_period_mon_ch
  import clk_period_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  input  logic             clr_err,
`ifdef CLK_PERIOD_MON_MINMAX_EN
  input  logic             clr_minmax,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
`endif
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic             pass,
  output logic             fail,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] ALL1 = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mon_q;
  logic             r_valid;
  logic [CNT_W-1:0] r_period;
  logic             r_pass;
  logic             r_fail;
  logic             r_err;

  logic             w_rise;
  logic             w_capture;
  logic             w_timeout;
  logic             w_ok;
  logic             w_fail_set;

  assign w_rise    = mon_in & ~r_mon_q;
  assign w_capture = (r_state == ST_MEAS) && w_rise;
  assign w_timeout = (r_state == ST_MEAS) && !w_rise
                     && (r_cnt == ALL1);

  // Counter value at a rise is the period; limits sampled now.
  assign w_ok = in_tol(MAX_W'(r_cnt),
                       MAX_W'(exp_period),
                       MAX_W'(tol));

  assign w_fail_set = en &&
    (w_timeout || (w_capture && !w_ok));

  // Registered copy of the monitored input, kept live while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mon_q <= 1'b0;
    end else begin
      r_mon_q <= mon_in;
    end
  end

  // Channel FSM, period counter and registered result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_ARM;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      if (!en) begin
        r_state <= ST_ARM;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_ARM: begin
            if (w_rise) begin
              r_state <= ST_MEAS;
              r_cnt   <= ONE;
            end
          end
          ST_MEAS: begin
            if (w_rise) begin
              r_cnt    <= ONE;
              r_valid  <= 1'b1;
              r_period <= r_cnt;
              r_pass   <= w_ok;
              r_fail   <= !w_ok;
            end else if (r_cnt == ALL1) begin
              r_state  <= ST_ARM;
              r_cnt    <= '0;
              r_valid  <= 1'b1;
              r_period <= ALL1;
              r_fail   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          default: begin
            r_state <= ST_ARM;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Sticky error: a new fail outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_fail_set) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign meas_valid  = r_valid;
  assign meas_period = r_period;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign err_sticky  = r_err;

`ifdef CLK_PERIOD_MON_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic             w_mm_cap;
  logic [CNT_W-1:0] w_min_base;
  logic [CNT_W-1:0] w_max_base;
  logic [CNT_W-1:0] w_min_nxt;
  logic [CNT_W-1:0] w_max_nxt;

  // Timeouts never reach min/max; only real captures do.
  assign w_mm_cap = en && w_capture;

  // Clear first, then fold in any capture from the same cycle.
  always_comb begin
    w_min_base = clr_minmax ? ALL1 : r_min;
    w_max_base = clr_minmax ? '0 : r_max;
    w_min_nxt  = w_min_base;
    w_max_nxt  = w_max_base;
    if (w_mm_cap && (r_cnt < w_min_base)) begin
      w_min_nxt = r_cnt;
    end
    if (w_mm_cap && (r_cnt > w_max_base)) begin
      w_max_nxt = r_cnt;
    end
  end

  // Running extremes of measured periods.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min <= ALL1;
      r_max <= '0;
    end else begin
      r_min <= w_min_nxt;
      r_max <= w_max_nxt;
    end
  end

  assign min_period = r_min;
  assign max_period = r_max;
`endif

endmodule

// File: rtl/clk_period_mon.sv
// clk_period_mon: NCH independent period checkers on one clock.
// Define CLK_PERIOD_MON_MINMAX_EN for min/max period tracking.
module clk_period_mon
  import clk_period_mon_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       mon_in,
  input  logic [CNT_W-1:0]     exp_period,
  input  logic [CNT_W-1:0]     tol,
  input  logic                 clr_err,
`ifdef CLK_PERIOD_MON_MINMAX_EN
  input  logic                 clr_minmax,
  output logic [NCH*CNT_W-1:0] min_period,
  output logic [NCH*CNT_W-1:0] max_period,
`endif
  output logic [NCH-1:0]       meas_valid,
  output logic [NCH*CNT_W-1:0] meas_period,
  output logic [NCH-1:0]       pass,
  output logic [NCH-1:0]       fail,
  output logic [NCH-1:0]       err_sticky
);

  // Shared controls fan out; per-channel results pack into vectors.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_period_mon_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mon_in     (mon_in[g]),
      .exp_period (exp_period),
      .tol        (tol),
      .clr_err    (clr_err),
`ifdef CLK_PERIOD_MON_MINMAX_EN
      .clr_minmax (clr_minmax),
      .min_period (min_period[g*CNT_W +: CNT_W]),
      .max_period (max_period[g*CNT_W +: CNT_W]),
`endif
      .meas_valid (meas_valid[g]),
      .meas_period(meas_period[g*CNT_W +: CNT_W]),
      .pass       (pass[g]),
      .fail       (fail[g]),
      .err_sticky (err_sticky[g])
    );
  end

endmodule

// File: tb/tb_clk_period_mon.sv
// Self-checking bench for clk_period_mon (NCH=4, CNT_W=8).
// Reference model works from rise timestamps, not counters.
module tb_clk_period_mon;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [NCH-1:0]       mon_in = '0;
  logic [CNT_W-1:0]     exp_period = '0;
  logic [CNT_W-1:0]     tol = '0;
  logic                 clr_err = 1'b0;
  logic                 clr_minmax = 1'b0;
  logic [NCH-1:0]       meas_valid;
  logic [NCH*CNT_W-1:0] meas_period;
  logic [NCH-1:0]       pass;
  logic [NCH-1:0]       fail;
  logic [NCH-1:0]       err_sticky;
`ifdef CLK_PERIOD_MON_MINMAX_EN
  logic [NCH*CNT_W-1:0] min_period;
  logic [NCH*CNT_W-1:0] max_period;
`endif

  clk_period_mon #(
    .NCH  (NCH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mon_in     (mon_in),
    .exp_period (exp_period),
    .tol        (tol),
    .clr_err    (clr_err),
`ifdef CLK_PERIOD_MON_MINMAX_EN
    .clr_minmax (clr_minmax),
    .min_period (min_period),
    .max_period (max_period),
`endif
    .meas_valid (meas_valid),
    .meas_period(meas_period),
    .pass       (pass),
    .fail       (fail),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;
  int now   = 0;

  // Reference model state
  bit                   m_armed [NCH];
  int                   m_last  [NCH];
  bit   [NCH-1:0]       m_prev;
  logic [NCH-1:0]       e_v, e_p, e_f, e_err;
  logic [NCH*CNT_W-1:0] e_mp, e_min, e_max;

  // Square wave of high hi / low lo cycles, phase off.
  function automatic bit wave(int t, int hi, int lo, int off);
    return ((t + off) % (hi + lo)) < hi;
  endfunction

  // Predict what the outputs hold after this cycle's clock edge.
  task automatic model_cycle();
    for (int c = 0; c < NCH; c++) begin
      int p;
      int ex;
      int tl;
      bit r;
      bit to;
      bit ok;
      e_v[c] = 1'b0;
      e_p[c] = 1'b0;
      e_f[c] = 1'b0;
      if (!rst_n) begin
        m_armed[c] = 1'b0;
        m_prev[c]  = 1'b0;
        e_err[c]   = 1'b0;
        e_mp[c*CNT_W +: CNT_W]  = '0;
        e_min[c*CNT_W +: CNT_W] = '1;
        e_max[c*CNT_W +: CNT_W] = '0;
        continue;
      end
      r  = mon_in[c] && !m_prev[c];
      m_prev[c] = mon_in[c];
      to = 1'b0;
      p  = 0;
      ex = int'(exp_period);
      tl = int'(tol);
      if (!en) begin
        m_armed[c] = 1'b0;
      end else if (r && m_armed[c]) begin
        p  = now - m_last[c];
        ok = ((p > ex) ? p - ex : ex - p) <= tl;
        e_v[c] = 1'b1;
        e_p[c] = ok;
        e_f[c] = !ok;
        m_last[c] = now;
      end else if (r) begin
        m_armed[c] = 1'b1;
        m_last[c]  = now;
      end else if (m_armed[c] && (now - m_last[c] == MAXV)) begin
        to = 1'b1;
        p  = MAXV;
        e_v[c] = 1'b1;
        e_f[c] = 1'b1;
        m_armed[c] = 1'b0;
      end
      if (e_v[c]) e_mp[c*CNT_W +: CNT_W] = CNT_W'(p);
      if (e_f[c]) e_err[c] = 1'b1;
      else if (clr_err) e_err[c] = 1'b0;
      if (clr_minmax) begin
        e_min[c*CNT_W +: CNT_W] = '1;
        e_max[c*CNT_W +: CNT_W] = '0;
      end
      if (e_v[c] && !to) begin
        if (p < int'(e_min[c*CNT_W +: CNT_W]))
          e_min[c*CNT_W +: CNT_W] = CNT_W'(p);
        if (p > int'(e_max[c*CNT_W +: CNT_W]))
          e_max[c*CNT_W +: CNT_W] = CNT_W'(p);
      end
    end
  endtask

  // Drive one cycle of mon_in and advance model and time.
  task automatic step(input logic [NCH-1:0] m);
    @(negedge clk);
    mon_in = m;
    model_cycle();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 3; i++) step(NCH'($urandom));
    nchk++;
    if ({meas_valid, pass, fail, err_sticky} !== '0)
      $display("FAIL reset_flags got %h want 0",
               {meas_valid, pass, fail, err_sticky});
    else npass++;
    nchk++;
    if (meas_period !== '0)
      $display("FAIL reset_period got %h want 0", meas_period);
    else npass++;
`ifdef CLK_PERIOD_MON_MINMAX_EN
    nchk++;
    if ({min_period, max_period} !== {{NCH*CNT_W{1'b1}}, {NCH*CNT_W{1'b0}}})
      $display("FAIL reset_minmax got %h/%h", min_period, max_period);
    else npass++;
`endif
    rst_n = 1'b1;
    step('0);
  endtask

  task automatic test_exact_pass();
    int off;
    int dut_n;
    int mod_n;
    off   = $urandom_range(0, 35);
    dut_n = 0;
    mod_n = 0;
    en = 1'b1;
    exp_period = 8'd36;
    tol = 8'd0;
    for (int t = 0; t < 200; t++) begin
      step({3'b000, wave(now, 18, 18, off)});
      dut_n += int'(pass[0]);
      mod_n += int'(e_p[0]);
      nchk++;
      if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
        $display("FAIL exact_pass_flags t=%0d got %h want %h", now,
                 {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
      else npass++;
      nchk++;
      if (meas_period !== e_mp)
        $display("FAIL exact_pass_period t=%0d got %h want %h",
                 now, meas_period, e_mp);
      else npass++;
    end
    nchk++;
    if (dut_n !== mod_n)
      $display("FAIL exact_pass_count got %0d want %0d", dut_n, mod_n);
    else npass++;
  endtask

  task automatic test_fail_clr();
    int off;
    int clr_at;
    off    = $urandom_range(0, 35);
    clr_at = $urandom_range(110, 150);
    exp_period = 8'd18;
    tol = 8'd0;
    for (int t = 0; t < 220; t++) begin
      clr_err = (t == clr_at) || (t == 60);
      step({3'b000, wave(now, 18, 18, off)});
      clr_err = 1'b0;
      nchk++;
      if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
        $display("FAIL fail_clr_flags t=%0d got %h want %h", now,
                 {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
      else npass++;
      nchk++;
      if (meas_period !== e_mp)
        $display("FAIL fail_clr_period t=%0d got %h want %h",
                 now, meas_period, e_mp);
      else npass++;
    end
  endtask

  task automatic test_tol();
    int hl [5];
    int ll [5];
    hl = '{19, 20, 17, 19, 17};
    ll = '{19, 19, 17, 18, 16};
    exp_period = 8'd36;
    tol = 8'd2;
    for (int s = 0; s < 5; s++) begin
      for (int t = 0; t < 130; t++) begin
        step({2'b00, wave(now, hl[s], ll[s], 0), 1'b0});
        nchk++;
        if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
          $display("FAIL tol_flags t=%0d got %h want %h", now,
                   {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
        else npass++;
        nchk++;
        if (meas_period !== e_mp)
          $display("FAIL tol_period t=%0d got %h want %h",
                   now, meas_period, e_mp);
        else npass++;
      end
    end
  endtask

  task automatic test_timeout();
    int to_seen;
    to_seen = 0;
    exp_period = 8'd36;
    tol = 8'd0;
    for (int t = 0; t < 360; t++) begin
      step({1'b0, (t >= 4) && (t < 300), 2'b00});
      if (meas_valid[2] && fail[2] && meas_period[2*CNT_W +: CNT_W] == 8'hFF)
        to_seen++;
      nchk++;
      if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
        $display("FAIL timeout_flags t=%0d got %h want %h", now,
                 {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
      else npass++;
      nchk++;
      if (meas_period !== e_mp)
        $display("FAIL timeout_period t=%0d got %h want %h",
                 now, meas_period, e_mp);
      else npass++;
    end
    nchk++;
    if (to_seen !== 1)
      $display("FAIL timeout_count got %0d want 1", to_seen);
    else npass++;
  endtask

  task automatic test_multi_reset();
    int hs [NCH];
    int off [NCH];
    int rst_at;
    logic [NCH-1:0] m;
    hs = '{5, 10, 18, 25};
    for (int c = 0; c < NCH; c++) off[c] = $urandom_range(0, 49);
    rst_at = $urandom_range(120, 160);
    exp_period = 8'd20;
    tol = 8'd0;
    for (int t = 0; t < 320; t++) begin
      for (int c = 0; c < NCH; c++) m[c] = wave(now, hs[c], hs[c], off[c]);
      rst_n = (t != rst_at);
      step(m);
      rst_n = 1'b1;
      nchk++;
      if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
        $display("FAIL multi_flags t=%0d got %h want %h", now,
                 {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
      else npass++;
      nchk++;
      if (meas_period !== e_mp)
        $display("FAIL multi_period t=%0d got %h want %h",
                 now, meas_period, e_mp);
      else npass++;
    end
  endtask

  task automatic test_random();
    int hi [NCH];
    int lo [NCH];
    int off [NCH];
    logic [NCH-1:0] m;
    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < NCH; c++) begin
        hi[c]  = $urandom_range(1, 30);
        lo[c]  = $urandom_range(1, 30);
        off[c] = $urandom_range(0, 59);
      end
      exp_period = CNT_W'(hi[0] + lo[0] + int'($urandom_range(0, 4)) - 2);
      tol = CNT_W'($urandom_range(0, 3));
      for (int t = 0; t < 180; t++) begin
        for (int c = 0; c < NCH; c++) m[c] = wave(now, hi[c], lo[c], off[c]);
        en = ($urandom_range(0, 59) != 0);
        clr_err = ($urandom_range(0, 29) == 0);
        clr_minmax = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0)
          exp_period = CNT_W'($urandom_range(0, 70));
        step(m);
        clr_err = 1'b0;
        clr_minmax = 1'b0;
        nchk++;
        if ({meas_valid, pass, fail, err_sticky} !== {e_v, e_p, e_f, e_err})
          $display("FAIL random_flags t=%0d got %h want %h", now,
                   {meas_valid, pass, fail, err_sticky}, {e_v, e_p, e_f, e_err});
        else npass++;
        nchk++;
        if (meas_period !== e_mp)
          $display("FAIL random_period t=%0d got %h want %h",
                   now, meas_period, e_mp);
        else npass++;
`ifdef CLK_PERIOD_MON_MINMAX_EN
        nchk++;
        if ({min_period, max_period} !== {e_min, e_max})
          $display("FAIL random_minmax t=%0d got %h/%h want %h/%h",
                   now, min_period, max_period, e_min, e_max);
        else npass++;
`endif
      end
    end
    en = 1'b1;
  endtask

`ifdef CLK_PERIOD_MON_MINMAX_EN
  task automatic test_minmax();
    int rises [4];
    bit hi;
    rises = '{5, 41, 75, 115};
    rst_n = 1'b0;
    step('0);
    rst_n = 1'b1;
    en = 1'b1;
    exp_period = 8'd36;
    tol = 8'd0;
    for (int k = 0; k < 130; k++) begin
      hi = 1'b0;
      for (int i = 0; i < 4; i++)
        if (k >= rises[i] && k < rises[i] + 3) hi = 1'b1;
      step({3'b000, hi});
      nchk++;
      if ({min_period, max_period} !== {e_min, e_max})
        $display("FAIL minmax_track t=%0d got %h/%h want %h/%h",
                 now, min_period, max_period, e_min, e_max);
      else npass++;
    end
    nchk++;
    if (min_period[CNT_W-1:0] !== 8'd34 || max_period[CNT_W-1:0] !== 8'd40)
      $display("FAIL minmax_ch0 got %0d/%0d want 34/40",
               min_period[CNT_W-1:0], max_period[CNT_W-1:0]);
    else npass++;
    clr_minmax = 1'b1;
    step('0);
    clr_minmax = 1'b0;
    nchk++;
    if (min_period[CNT_W-1:0] !== 8'hFF || max_period[CNT_W-1:0] !== 8'h00)
      $display("FAIL minmax_clr got %h/%h want ff/00",
               min_period[CNT_W-1:0], max_period[CNT_W-1:0]);
    else npass++;
  endtask
`endif

  initial begin
    m_prev = '0;
    e_v = '0; e_p = '0; e_f = '0; e_err = '0;
    e_mp = '0; e_min = '1; e_max = '0;
    for (int c = 0; c < NCH; c++) begin
      m_armed[c] = 1'b0;
      m_last[c]  = 0;
    end
    test_reset();
    test_exact_pass();
    test_fail_clr();
    test_tol();
    test_timeout();
    test_multi_reset();
    test_random();
`ifdef CLK_PERIOD_MON_MINMAX_EN
    test_minmax();
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
